// File: rtl/pe_ctrl_seq.sv
// pe_ctrl_seq: sequencer for the PE array on one layer tile.
// It runs K accumulation passes over N PE-buffer entries and then a flush sweep.
// Pass 0 accumulates onto the bias; later passes accumulate onto the buffered partial sum.
// A MACC_LAT-deep delay line turns each issued operand into a buffer write
// (wr_req) or, during flush, into an output strobe (write_valid).

`ifndef SRC_2_BIAS
`define SRC_2_BIAS 1'b0
`endif

module pe_ctrl_seq #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int OP_CODE_WIDTH     = 3,
    parameter int CNT_WIDTH         = 16,
    parameter int MACC_LAT          = 3,
    localparam int CTRL_WIDTH       = 10 + 2 * PE_BUF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PE_BUF_ADDR_WIDTH:0]   cfg_num_out,
    input  logic [CNT_WIDTH-1:0]         cfg_num_pass,
    input  logic [OP_CODE_WIDTH-1:0]     cfg_op_code,
    input  logic                         step,
    output logic [CTRL_WIDTH-1:0]        ctrl,
    output logic                         src_2_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int AW = PE_BUF_ADDR_WIDTH;

    // Constants sized to their counters so arithmetic stays width-matched.
    localparam logic [AW:0]          ADDR_ONE   = (AW + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] PASS_ONE   = CNT_WIDTH'(1);
    // Smallest N that lets a pass-(p+1) read land after the pass-p write of the same entry.
    localparam logic [AW:0]          HAZARD_MIN = (AW + 1)'(MACC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN_ACC,
        S_FLUSH,
        S_DRAIN_FL
    } state_t;

    state_t                 state_q, state_d;
    logic [AW:0]            addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   pass_q, pass_d;
    logic [AW:0]            num_out_q, num_out_d;
    logic [CNT_WIDTH-1:0]   num_pass_q, num_pass_d;
    logic [OP_CODE_WIDTH-1:0] op_q, op_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;

    // Delay line: one entry per issued operand, tagged WR (accumulate) or FL (flush).
    logic                   dl_vld_q  [MACC_LAT];
    logic                   dl_fl_q   [MACC_LAT];
    logic [AW-1:0]          dl_addr_q [MACC_LAT];

    logic                   push_vld;
    logic                   push_fl;
    logic                   dl_any;
    logic                   dl_pending;

    logic                   issue;
    logic                   flush_rd;
    logic                   cfg_bad;
    logic                   last_addr;
    logic                   last_pass;

    // Configuration screening applied to a start seen in IDLE.
    always_comb begin
        cfg_bad = (cfg_num_out == '0) ||
                  (cfg_num_pass == '0) ||
                  ((cfg_num_pass > PASS_ONE) && (cfg_num_out < HAZARD_MIN));
    end

    // End-of-sweep and end-of-tile position flags.
    always_comb begin
        last_addr = (addr_q == (num_out_q - ADDR_ONE));
        last_pass = (pass_q == (num_pass_q - PASS_ONE));
    end

    // Delay-line occupancy: dl_any covers every stage; dl_pending excludes the
    // output stage, i.e. "something is still in flight after this cycle".
    always_comb begin
        dl_any     = 1'b0;
        dl_pending = 1'b0;
        for (int i = 0; i < MACC_LAT; i++) begin
            dl_any = dl_any | dl_vld_q[i];
            if (i < MACC_LAT - 1) begin
                dl_pending = dl_pending | dl_vld_q[i];
            end
        end
    end

    // Next-state logic for the sequencer and its counters.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        num_out_d  = num_out_q;
        num_pass_d = num_pass_q;
        op_d       = op_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        push_vld   = 1'b0;
        push_fl    = 1'b0;
        issue      = 1'b0;
        flush_rd   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        num_out_d  = cfg_num_out;
                        num_pass_d = cfg_num_pass;
                        op_d       = cfg_op_code;
                        addr_d     = '0;
                        pass_d     = '0;
                        state_d    = S_ACC;
                    end
                end
            end

            S_ACC: begin
                if (step) begin
                    issue    = 1'b1;
                    push_vld = 1'b1;
                    if (last_addr) begin
                        addr_d = '0;
                        pass_d = pass_q + PASS_ONE;
                        if (last_pass) begin
                            state_d = S_DRAIN_ACC;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end

            S_DRAIN_ACC: begin
                // Wait until the final accumulate write has fully left the
                // line so flush reads observe committed sums.
                if (!dl_any) begin
                    addr_d  = '0;
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                flush_rd = 1'b1;
                push_vld = 1'b1;
                push_fl  = 1'b1;
                if (last_addr) begin
                    addr_d  = '0;
                    state_d = S_DRAIN_FL;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end

            S_DRAIN_FL: begin
                // The last write_valid is at the output this cycle; done
                // follows in IDLE so busy is already low alongside it.
                if (!dl_pending) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            num_out_q  <= '0;
            num_pass_q <= '0;
            op_q       <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            num_out_q  <= num_out_d;
            num_pass_q <= num_pass_d;
            op_q       <= op_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Delay-line head: capture this cycle's issue (or a bubble).
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_vld_q[0]  <= 1'b0;
            dl_fl_q[0]   <= 1'b0;
            dl_addr_q[0] <= '0;
        end else begin
            dl_vld_q[0]  <= push_vld;
            dl_fl_q[0]   <= push_fl;
            dl_addr_q[0] <= push_vld ? addr_q[AW-1:0] : '0;
        end
    end

    // Remaining delay-line stages shift unconditionally every cycle.
    generate
        for (genvar gi = 1; gi < MACC_LAT; gi++) begin : g_dl
            always_ff @(posedge clk) begin
                if (reset) begin
                    dl_vld_q[gi]  <= 1'b0;
                    dl_fl_q[gi]   <= 1'b0;
                    dl_addr_q[gi] <= '0;
                end else begin
                    dl_vld_q[gi]  <= dl_vld_q[gi-1];
                    dl_fl_q[gi]   <= dl_fl_q[gi-1];
                    dl_addr_q[gi] <= dl_addr_q[gi-1];
                end
            end
        end
    endgenerate

    logic          rd_req;
    logic          wr_req;
    logic          write_valid;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [2:0]    op_slot;

    // Control word fields; everything idles at zero so reset leaves ctrl=0.
    always_comb begin
        rd_req      = (issue && (pass_q != '0)) || flush_rd;
        rd_addr     = (issue || flush_rd) ? addr_q[AW-1:0] : '0;
        wr_req      = dl_vld_q[MACC_LAT-1] && !dl_fl_q[MACC_LAT-1];
        write_valid = dl_vld_q[MACC_LAT-1] && dl_fl_q[MACC_LAT-1];
        wr_addr     = dl_vld_q[MACC_LAT-1] ? dl_addr_q[MACC_LAT-1] : '0;
        op_slot     = issue ? 3'(op_q) : 3'b000;
        src_2_sel   = 1'b0;
        if (issue) begin
            src_2_sel = (pass_q == '0) ? `SRC_2_BIAS : ~`SRC_2_BIAS;
        end
    end

    // LRN push/pop are not driven by this sequencer and stay low.
    assign ctrl = {1'b0, 1'b0, rd_addr, wr_addr, flush_rd, write_valid,
                   wr_req, rd_req, issue, op_slot};

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Testbench for pe_ctrl_seq: random tiles against a scoreboard of timed events.

`ifndef SRC_2_BIAS
`define SRC_2_BIAS 1'b0
`endif

module tb_pe_ctrl_seq;

    localparam int AW  = 10;
    localparam int LAT = 3;

    localparam int Q_ISS  = 0;
    localparam int Q_WR   = 1;
    localparam int Q_FL   = 2;
    localparam int Q_WV   = 3;
    localparam int Q_DONE = 4;
    localparam int Q_ERR  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW:0]       cfg_num_out;
    logic [15:0]       cfg_num_pass;
    logic [2:0]        cfg_op_code;
    logic              step;
    logic [29:0]       ctrl;
    logic              src_2_sel;
    logic              busy;
    logic              done;
    logic              cfg_err;

    pe_ctrl_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_num_out  (cfg_num_out),
        .cfg_num_pass (cfg_num_pass),
        .cfg_op_code  (cfg_op_code),
        .step         (step),
        .ctrl         (ctrl),
        .src_2_sel    (src_2_sel),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ctrl fields, decoded from the documented field order (LSB = op_code).
    logic [2:0]    c_op;
    logic          c_en, c_rdreq, c_wrreq, c_wv, c_fl, c_npop, c_npush;
    logic [AW-1:0] c_wra, c_rda;
    assign c_op    = ctrl[2:0];
    assign c_en    = ctrl[3];
    assign c_rdreq = ctrl[4];
    assign c_wrreq = ctrl[5];
    assign c_wv    = ctrl[6];
    assign c_fl    = ctrl[7];
    assign c_wra   = ctrl[17:8];
    assign c_rda   = ctrl[27:18];
    assign c_npop  = ctrl[28];
    assign c_npush = ctrl[29];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          t;
        logic [31:0] v;
    } ev_t;

    ev_t q [6][$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void push(input int qi, input int t, input logic [31:0] v);
        ev_t e;
        e.t = t;
        e.v = v;
        q[qi].push_back(e);
    endfunction

    task automatic mon_pop(input int qi, input string name, input logic [31:0] v);
        ev_t e;
        checks++;
        if (q[qi].size() == 0) begin
            failures++;
            $display("FAIL %s: got event at cycle %0d value %h, required none", name, cyc, v);
        end else begin
            e = q[qi].pop_front();
            if (e.t != cyc || e.v !== v) begin
                failures++;
                $display("FAIL %s: got cycle %0d value %h, required cycle %0d value %h",
                         name, cyc, v, e.t, e.v);
            end
        end
    endtask

    // Drop expectations that a reset cancelled.
    task automatic purge_after(input int r);
        ev_t tmp[$];
        for (int qi = 0; qi < 6; qi++) begin
            tmp = q[qi];
            q[qi] = {};
            foreach (tmp[j]) begin
                if (tmp[j].t <= r) q[qi].push_back(tmp[j]);
            end
        end
    endtask

    // Monitor: whenever the DUT presents an event, pop and compare.
    always @(negedge clk) begin
        if (mon_en) begin
            if (c_en === 1'b1)
                mon_pop(Q_ISS, "issue", 32'({c_rdreq, src_2_sel, c_op, c_rda}));
            else
                chk("src_2_sel_idle", 32'(src_2_sel), 32'(0));
            if (c_fl === 1'b1)
                mon_pop(Q_FL, "flush_rd", 32'({c_rdreq, c_en, c_rda}));
            if (c_wrreq === 1'b1)
                mon_pop(Q_WR, "wr_req", 32'({c_wv, c_wra}));
            if (c_wv === 1'b1)
                mon_pop(Q_WV, "write_valid", 32'(c_wrreq));
            if (done === 1'b1)
                mon_pop(Q_DONE, "done", 32'(busy));
            if (cfg_err === 1'b1)
                mon_pop(Q_ERR, "cfg_err", 32'(busy));
            chk("norm_bits", 32'({c_npush, c_npop}), 32'(0));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One tile request. mode 0: step always 1; mode 1: 1,0,0 repeating; mode 2: random.
    // Returns in the cycle after done (or after the cfg_err cycle).
    task automatic run_tile(input int n, input int k, input int mode, input bit start_in_flush);
        int s, b, c, lastc, fl0, done_c, nk;
        logic [2:0] op;
        bit stp;
        op = 3'($urandom);
        s  = cyc;
        nk = n * k;
        start        = 1'b1;
        cfg_num_out  = (AW + 1)'(n);
        cfg_num_pass = 16'(k);
        cfg_op_code  = op;
        step         = 1'($urandom);
        $display("tile n=%0d k=%0d mode=%0d at cycle %0d", n, k, mode, s);
        if (n == 0 || k == 0 || (k > 1 && n < LAT + 1)) begin
            push(Q_ERR, s + 1, 32'(0));
            next_cycle();
            start = 1'b0;
            chk("busy_after_reject", 32'(busy), 32'(0));
            return;
        end
        next_cycle();
        start        = 1'b0;
        cfg_num_out  = (AW + 1)'($urandom);
        cfg_num_pass = 16'($urandom);
        cfg_op_code  = 3'($urandom);
        chk("busy_after_start", 32'(busy), 32'(1));
        b = 0;
        c = 0;
        lastc = 0;
        while (b < nk) begin
            case (mode)
                0:       stp = 1'b1;
                1:       stp = (c % 3 == 0);
                default: stp = ($urandom_range(0, 2) != 0);
            endcase
            c++;
            step  = stp;
            start = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (stp) begin
                push(Q_ISS, cyc, 32'({(b / n) > 0, ((b / n) == 0) ? `SRC_2_BIAS : ~`SRC_2_BIAS,
                                      op, AW'(b % n)}));
                push(Q_WR, cyc + LAT, 32'({1'b0, AW'(b % n)}));
                if (b == nk - 1) lastc = cyc;
                b++;
            end
            next_cycle();
        end
        start  = 1'b0;
        fl0    = lastc + LAT + 2;
        done_c = lastc + 2 * LAT + n + 2;
        for (int i = 0; i < n; i++) begin
            push(Q_FL, fl0 + i, 32'({1'b1, 1'b0, AW'(i)}));
            push(Q_WV, fl0 + i + LAT, 32'(0));
        end
        push(Q_DONE, done_c, 32'(0));
        while (cyc < done_c + 1) begin
            step = 1'($urandom);
            if (start_in_flush && cyc == fl0 + 1) begin
                start        = 1'b1;
                cfg_num_out  = (AW + 1)'(4);
                cfg_num_pass = 16'(1);
            end else begin
                start = 1'b0;
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    // Reset while in pass 1, addr 2 of an N=4,K=2 tile.
    task automatic reset_mid_tile();
        int s;
        logic [2:0] op;
        op = 3'($urandom);
        s  = cyc;
        start        = 1'b1;
        cfg_num_out  = (AW + 1)'(4);
        cfg_num_pass = 16'(2);
        cfg_op_code  = op;
        $display("reset-mid tile at cycle %0d", s);
        next_cycle();
        start = 1'b0;
        step  = 1'b1;
        for (int bb = 0; bb < 7; bb++) begin
            push(Q_ISS, cyc, 32'({(bb / 4) > 0, ((bb / 4) == 0) ? `SRC_2_BIAS : ~`SRC_2_BIAS,
                                  op, AW'(bb % 4)}));
            push(Q_WR, cyc + LAT, 32'({1'b0, AW'(bb % 4)}));
            if (bb == 6) reset = 1'b1;
            next_cycle();
        end
        reset = 1'b0;
        purge_after(cyc - 1);
        chk("ctrl_after_midreset", 32'(ctrl), 32'(0));
        chk("busy_after_midreset", 32'(busy), 32'(0));
        chk("src_after_midreset", 32'(src_2_sel), 32'(0));
        repeat (12) next_cycle();
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        step         = 1'b0;
        cfg_num_out  = '0;
        cfg_num_pass = '0;
        cfg_op_code  = '0;
        repeat (3) next_cycle();
        chk("reset_ctrl", 32'(ctrl), 32'(0));
        chk("reset_src", 32'(src_2_sel), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_cfg_err", 32'(cfg_err), 32'(0));
        reset  = 1'b0;
        mon_en = 1'b1;
        next_cycle();

        run_tile(4, 1, 0, 1'b0);
        run_tile(4, 3, 0, 1'b0);
        run_tile(4, 2, 1, 1'b0);
        run_tile(2, 2, 0, 1'b0);
        run_tile(0, 1, 0, 1'b0);
        run_tile(4, 0, 0, 1'b0);
        run_tile(2, 1, 0, 1'b0);
        run_tile(1, 1, 0, 1'b0);
        reset_mid_tile();
        run_tile(4, 1, 0, 1'b0);
        run_tile(8, 2, 0, 1'b1);
        run_tile(4, 2, 0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_tile($urandom_range(1, 20), $urandom_range(1, 4), $urandom_range(0, 2), 1'b0);
        end
        run_tile(1024, 1, 0, 1'b0);

        repeat (10) next_cycle();
        for (int qi = 0; qi < 6; qi++) begin
            chk("leftover_expected_events", 32'(q[qi].size()), 32'(0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
